// File: rtl/dbus_pkg.sv
// Shared types and constants for the core data-bus bridge.
// State encoding is fixed so the values are stable across any waveform or debug tooling.
package dbus_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWpost = 2'd1,
      StRd    = 2'd2,
      StRdone = 2'd3
   } dbus_state_e;

   localparam logic [31:0] DBUS_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/core_dbus_bridge_if.sv
// Request/acknowledge bus between the data bridge (master) and SoC memory/peripherals (slave).
interface core_dbus_bridge_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/dbus_timeout_cnt.sv
// Counts request cycles without acknowledge; hit marks the last cycle a request may stay open.
module dbus_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic res,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q;

   // Saturates at the last cycle; the bridge closes the request there anyway.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !hit) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hit = en & (cnt_q == LastCnt);

endmodule

// File: rtl/core_dbus_bridge.sv
// Bridges the core's single-cycle load/store port onto a variable-latency req/ack bus.
// Stores are posted through a one-entry buffer, loads stall the core until data returns.
module core_dbus_bridge
   import dbus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = DBUS_ERR_RDATA
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic                      ext_halt,
   input  logic [31:0]               core_addr,
   input  logic [31:0]               core_wdata,
   input  logic [3:0]                core_be,
   input  logic                      core_re,
   input  logic                      core_we,
   output logic [31:0]               core_rdata,
   output logic                      core_halt,
   output logic                      bus_err,
   core_dbus_bridge_if.master        mem
);

   dbus_state_e state_q, state_d;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic busy;
   logic ack;
   logic hit;
   logic timeout;
   logic launch_rd;
   logic launch_wr;
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^core_addr[1:0];

   assign busy      = (state_q == StWpost) || (state_q == StRd);
   assign ack       = busy & mem.mem_ack;
   // An ack arriving in the final allowed cycle still completes the transfer.
   assign timeout   = hit & ~mem.mem_ack;
   assign launch_rd = (state_q == StIdle) & core_re;
   assign launch_wr = (state_q == StIdle) & core_we & ~core_re;

   dbus_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk (clk),
      .res (res),
      .clr (state_q == StIdle),
      .en  (busy),
      .hit (hit)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (core_re) begin
               state_d = StRd;
            end else if (core_we) begin
               state_d = StWpost;
            end
         end
         StWpost: if (ack || timeout) state_d = StIdle;
         StRd:    if (ack || timeout) state_d = StRdone;
         StRdone: if (!ext_halt) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (launch_rd || launch_wr) begin
            addr_q <= {core_addr[31:2], 2'b00};
            be_q   <= core_be;
         end
         if (launch_wr) begin
            wdata_q <= core_wdata;
         end
         if (state_q == StRd) begin
            if (ack) begin
               rdata_q <= mem.mem_rdata;
            end else if (timeout) begin
               rdata_q <= ERR_RDATA;
            end
         end
         if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      mem.mem_req   = busy;
      mem.mem_we    = (state_q == StWpost);
      mem.mem_addr  = addr_q;
      mem.mem_wdata = wdata_q;
      mem.mem_be    = be_q;
      core_rdata    = rdata_q;
      bus_err       = err_q;
      // A store in idle retires without stall; everything else waits for the bus.
      core_halt     = ~res | ext_halt | (state_q == StRd)
                    | ((core_re | core_we) & ((state_q != StIdle) | core_re)
                       & (state_q != StRdone));
   end

endmodule

// File: tb/tb_core_dbus_bridge.sv
// Directed bench for core_dbus_bridge with a cycle-level reference model and literal checks.
module tb_core_dbus_bridge;

   localparam int unsigned TO   = 8;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        ext_halt = 1'b0;
   logic [31:0] core_addr = '0;
   logic [31:0] core_wdata = '0;
   logic [3:0]  core_be = '0;
   logic        core_re = 1'b0;
   logic        core_we = 1'b0;
   logic [31:0] core_rdata;
   logic        core_halt;
   logic        bus_err;

   core_dbus_bridge_if mem_bus ();

   core_dbus_bridge #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .res        (res),
      .ext_halt   (ext_halt),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_be    (core_be),
      .core_re    (core_re),
      .core_we    (core_we),
      .core_rdata (core_rdata),
      .core_halt  (core_halt),
      .bus_err    (bus_err),
      .mem        (mem_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave: acks in its lat-th request cycle (lat = 0 never acks), logs completed transfers.
   int          lat = 1;
   logic [31:0] rd_value = '0;
   int          req_age = 0;
   logic        ev_we[$];
   logic [31:0] ev_addr[$];

   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_bus.mem_req) req_age++;
         else req_age = 0;
         mem_bus.mem_ack   = (lat != 0) && (req_age == lat);
         mem_bus.mem_rdata = mem_bus.mem_ack ? rd_value : 32'hA5A5_A5A5;
         if (mem_bus.mem_ack) begin
            ev_we.push_back(mem_bus.mem_we);
            ev_addr.push_back(mem_bus.mem_addr);
         end
      end
   end

   // Reference model: what is outstanding (0 none, 1 write, 2 read, 3 data ready) and its age.
   int          m_kind = 0;
   int          m_age = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   logic [3:0]  m_be = '0;
   logic        m_err = 1'b0;

   always @(negedge clk) begin : model
      logic e_halt, e_req, acc, ack, tmo;
      if (!res) begin
         chk("rst core_halt", core_halt, 1'b1);
         chk("rst mem_req", mem_bus.mem_req, 1'b0);
         chk("rst mem_we", mem_bus.mem_we, 1'b0);
         chk("rst mem_addr", mem_bus.mem_addr, 32'h0);
         chk("rst mem_wdata", mem_bus.mem_wdata, 32'h0);
         chk("rst mem_be", mem_bus.mem_be, 32'h0);
         chk("rst core_rdata", core_rdata, 32'h0);
         chk("rst bus_err", bus_err, 1'b0);
         m_kind = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
         m_err = 1'b0;
      end else begin
         acc    = core_re | core_we;
         e_halt = ext_halt || (m_kind == 2) ||
                  (acc && (m_kind != 3) && ((m_kind != 0) || core_re));
         e_req  = (m_kind == 1) || (m_kind == 2);
         chk("core_halt", core_halt, e_halt);
         chk("mem_req", mem_bus.mem_req, e_req);
         chk("mem_we", mem_bus.mem_we, m_kind == 1);
         chk("bus_err", bus_err, m_err);
         if (e_req) begin
            chk("mem_addr", mem_bus.mem_addr, m_addr);
            chk("mem_be", mem_bus.mem_be, m_be);
            if (m_kind == 1) chk("mem_wdata", mem_bus.mem_wdata, m_wdata);
         end
         if (m_kind == 3) chk("core_rdata", core_rdata, m_rdata);
         ack = e_req && mem_bus.mem_ack;
         tmo = e_req && !ack && (m_age == TO - 1);
         case (m_kind)
            0: begin
               m_age = 0;
               if (core_re || core_we) begin
                  m_addr = {core_addr[31:2], 2'b00};
                  m_be   = core_be;
                  m_kind = core_re ? 2 : 1;
                  if (!core_re) m_wdata = core_wdata;
               end
            end
            1, 2: begin
               if (ack) begin
                  if (m_kind == 2) m_rdata = mem_bus.mem_rdata;
                  m_kind = (m_kind == 2) ? 3 : 0;
               end else if (tmo) begin
                  m_err = 1'b1;
                  if (m_kind == 2) m_rdata = ERRD;
                  m_kind = (m_kind == 2) ? 3 : 0;
               end else begin
                  m_age++;
               end
            end
            default: if (!ext_halt) m_kind = 0;
         endcase
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      core_re = 1'b0;
      core_we = 1'b0;
   endtask

   // Presents one access like the core would and holds it until core_halt is low.
   task automatic access(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int stalls, output logic [31:0] rdata);
      bit done = 0;
      core_re = re; core_we = we; core_addr = addr; core_wdata = wdata; core_be = be;
      stalls = 0;
      rdata  = '0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (core_halt) stalls++;
         else begin
            rdata = core_rdata;
            done  = 1;
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL access_bound: core_halt still 1 after 200 cycles, want release");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      ext_halt = 1'b0;
      res = 1'b0;
      cycles(2);
      res = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          st;
      logic [31:0] rd;

      cycles(2);
      chk("rst lit mem_req", mem_bus.mem_req, 1'b0);
      chk("rst lit core_halt", core_halt, 1'b1);
      res = 1'b1;
      cycles(1);

      // 1: single-cycle slave load, unaligned core address.
      lat = 1; rd_value = 32'h12345678; ev_addr.delete(); ev_we.delete();
      access(1, 0, 32'h102, 32'h0, 4'hF, st, rd);
      idle();
      chk("t1 stalls", st, 2);
      chk("t1 rdata", rd, 32'h12345678);
      chk("t1 word addr", ev_addr[0], 32'h100);
      cycles(2);

      // 2: store then dependent load, latency 3.
      lat = 3; rd_value = 32'h0BADC0DE; ev_addr.delete(); ev_we.delete();
      access(0, 1, 32'h200, 32'hCAFEF00D, 4'hF, st, rd);
      chk("t2 store stalls", st, 0);
      access(1, 0, 32'h200, 32'h0, 4'hF, st, rd);
      idle();
      chk("t2 load stalls", st, 7);
      chk("t2 load data", rd, 32'h0BADC0DE);
      chk("t2 xfer count", ev_we.size(), 2);
      chk("t2 write first", ev_we[0], 1'b1);
      chk("t2 read second", ev_we[1], 1'b0);
      cycles(2);

      // 3: back-to-back stores, latency 4.
      lat = 4; ev_addr.delete(); ev_we.delete();
      access(0, 1, 32'h300, 32'h11112222, 4'h3, st, rd);
      chk("t3 store1 stalls", st, 0);
      access(0, 1, 32'h304, 32'h33334444, 4'hC, st, rd);
      idle();
      chk("t3 store2 stalls", st, 4);
      cycles(6);
      chk("t3 xfer count", ev_we.size(), 2);
      chk("t3 store2 addr", ev_addr[1], 32'h304);

      // 4: dead slave, timeout after 8 request cycles.
      lat = 0;
      access(1, 0, 32'h400, 32'h0, 4'hF, st, rd);
      idle();
      chk("t4 stalls", st, 9);
      chk("t4 err data", rd, 32'hDEADBEEF);
      chk("t4 bus_err", bus_err, 1'b1);
      cycles(3);
      chk("t4 bus_err sticky", bus_err, 1'b1);
      chk("t4 mem_req", mem_bus.mem_req, 1'b0);

      // 5: ext_halt holds RDONE; then ack lands on the timeout cycle.
      do_reset();
      cycles(1);
      chk("t5 err cleared", bus_err, 1'b0);
      lat = 1; rd_value = 32'h5A5A0001;
      ext_halt = 1'b1; core_re = 1'b1; core_addr = 32'h500; core_be = 4'hF;
      cycles(2);
      rd_value = 32'h77777777;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5 held halt", core_halt, 1'b1);
         chk("t5 held rdata", core_rdata, 32'h5A5A0001);
         @(posedge clk);
         #1;
      end
      ext_halt = 1'b0;
      @(negedge clk);
      chk("t5 release halt", core_halt, 1'b0);
      chk("t5 release rdata", core_rdata, 32'h5A5A0001);
      @(posedge clk);
      #1;
      idle();
      cycles(1);
      lat = TO; rd_value = 32'h0000ACED;
      access(1, 0, 32'h504, 32'h0, 4'hF, st, rd);
      idle();
      chk("t5 late ack stalls", st, 9);
      chk("t5 late ack data", rd, 32'h0000ACED);
      chk("t5 no bus_err", bus_err, 1'b0);
      cycles(1);

      // 6: reset mid-load, then a normal load.
      lat = 0;
      core_re = 1'b1; core_addr = 32'h600; core_be = 4'hF;
      cycles(3);
      chk("t6 in flight", mem_bus.mem_req, 1'b1);
      #2;
      res = 1'b0;
      #1;
      chk("t6 async req drop", mem_bus.mem_req, 1'b0);
      chk("t6 halt in reset", core_halt, 1'b1);
      @(posedge clk);
      #1;
      lat = 1; rd_value = 32'h600D600D;
      res = 1'b1;
      access(1, 0, 32'h600, 32'h0, 4'hF, st, rd);
      idle();
      chk("t6 stalls", st, 2);
      chk("t6 data", rd, 32'h600D600D);
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
